can_tx_framer: RTL

- Builds a CAN 2.0A base-format data or remote frame from parallel fields and transmits it serially at the bit rate.
- Phase 1 (BUILD) streams the unstuffed SOF..data bits, one per clk, into the downstream serial CRC-15 stage (poly 0x4599). The CRC stage updates on every clk while its enable is high and clears when enable is low.
- Phase 2 (TX) captures the CRC result, then shifts out the complete frame paced by bit_tick. This covers the bit-stuffed region, the fixed-form tail and the interframe space (IFS).

---
 rtl/can_pkg.sv | 29 ++
 rtl/can_bit_stuffer.sv | 54 +++++
 rtl/can_tx_framer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared constants and FSM state type for the CAN 2.0A base-frame transmitter.
// Contents:
//   CAN_HDR_BITS    : SOF..DLC bit count (frame with zero data bytes)
//   CAN_CRC_BITS    : CRC field width
//   CAN_TAIL_BITS   : CRC delimiter + ACK slot + ACK delimiter + 7-bit EOF
//   CAN_STUFF_LIMIT : run length that forces a stuff bit
//   CAN_CRC_POLY    : CRC-15 generator polynomial used by the downstream CRC stage
//   CAN_BUF_BITS    : frame buffer width (largest header + data + CRC)
//   can_state_e     : transmitter FSM states
package can_pkg;

  localparam int          CAN_HDR_BITS    = 19;
  localparam int          CAN_CRC_BITS    = 15;
  localparam int          CAN_TAIL_BITS   = 10;
  localparam int          CAN_STUFF_LIMIT = 5;
  localparam logic [14:0] CAN_CRC_POLY    = 15'h4599;
  localparam int          CAN_BUF_BITS    = 98;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_CAPT,
    ST_WAIT,
    ST_TX_STUFF,
    ST_TX_TAIL,
    ST_IFS
  } can_state_e;

endpackage

// File: rtl/can_bit_stuffer.sv
// Bit-rate output stage: drives the serial line and inserts stuff bits.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (line goes recessive)
//   tick_i        : one-clk pulse per CAN bit time
//   en_i          : stuffed region active; when low a tick drives recessive and
//                   clears the run counter
//   bit_i         : next frame bit to transmit
//   tx_bit_o      : registered serial line (1 = recessive)
//   consume_o     : frame bit bit_i was sent this tick (low on stuff ticks)
//   stuff_pend_o  : the next stuffed-region tick will carry a stuff bit
module can_bit_stuffer
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic en_i,
  input  logic bit_i,
  output logic tx_bit_o,
  output logic consume_o,
  output logic stuff_pend_o
);

  logic       tx_q;
  logic [2:0] run_q;
  logic       out_bit;

  assign stuff_pend_o = (run_q == 3'(CAN_STUFF_LIMIT));
  // A stuff bit is the complement of the last transmitted bit.
  assign out_bit      = stuff_pend_o ? ~tx_q : bit_i;
  assign consume_o    = tick_i && en_i && !stuff_pend_o;
  assign tx_bit_o     = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q  <= 1'b1;
      run_q <= '0;
    end else if (tick_i) begin
      if (en_i) begin
        tx_q <= out_bit;
        // run_q == 0 marks "no previous bit" so SOF always opens a run of 1.
        if ((run_q == 3'd0) || (out_bit != tx_q)) begin
          run_q <= 3'd1;
        end else begin
          run_q <= run_q + 3'd1;
        end
      end else begin
        tx_q  <= 1'b1;
        run_q <= '0;
      end
    end
  end

endmodule

// File: rtl/can_tx_framer.sv
// CAN 2.0A base-format data/remote frame transmitter.
// Builds the unstuffed SOF..data bit stream into an external serial CRC-15
// stage (one bit per clk), captures the CRC, then sends the stuffed region,
// the fixed tail and the interframe space paced by bit_tick.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (aborts any frame)
//   start / ready   : frame request, accepted when start && ready
//   id, rtr, dlc    : header fields, captured on accept
//   data            : payload, byte0 = data[63:56], captured on accept
//   bit_tick        : one-clk pulse per CAN bit time
//   crc_en, crc_bit : serial feed to the CRC stage (enable high for N clks)
//   crc_frm         : CRC stage result, sampled in ST_CAPT
//   tx_bit          : serial line, 1 = recessive
//   busy            : any state other than idle
//   done            : one-clk pulse after the interframe space
module can_tx_framer
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int IFS_BITS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        bit_tick,
  output logic        crc_en,
  output logic        crc_bit,
  input  logic [14:0] crc_frm,
  output logic        tx_bit,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] TOP_IDX = 7'(CAN_BUF_BITS - 1);

  can_state_e  state_q;
  logic        ready_q, busy_q, done_q, crc_en_q, crc_bit_q;
  logic [6:0]  idx_q;
  logic [6:0]  n_q;
  logic [3:0]  cnt_q;
  logic [97:0] buf_q;

  logic [3:0]  nbytes;
  logic [6:0]  n_d;
  logic [6:0]  end_idx;
  logic [6:0]  crc_sh;
  logic        accept, frame_bit, region_en, consume, stuff_pend;

  assign accept    = (state_q == ST_IDLE) && start;
  assign nbytes    = rtr ? 4'd0 : ((dlc > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc);
  assign n_d       = 7'(CAN_HDR_BITS) + {nbytes, 3'b000};
  // One past the last CRC bit: all stuffed-region frame bits are consumed here.
  assign end_idx   = n_q + 7'(CAN_CRC_BITS);
  // LSB position of the CRC field inside the MSB-first buffer.
  assign crc_sh    = 7'(CAN_BUF_BITS - CAN_CRC_BITS) - n_q;
  // Frame bit k lives at buf_q[97-k].
  assign frame_bit = buf_q[TOP_IDX - idx_q];
  // Stay in the stuffed region after the last CRC bit while a stuff bit is owed.
  assign region_en = (state_q == ST_WAIT) ||
                     ((state_q == ST_TX_STUFF) && ((idx_q != end_idx) || stuff_pend));

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_en  = crc_en_q;
  assign crc_bit = crc_bit_q;

  // Ticks outside the stuffed region simply hold the line recessive, so the
  // stuffer can see every bit_tick, including those ignored during BUILD.
  can_bit_stuffer u_stuffer (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (bit_tick),
    .en_i         (region_en),
    .bit_i        (frame_bit),
    .tx_bit_o     (tx_bit),
    .consume_o    (consume),
    .stuff_pend_o (stuff_pend)
  );

  // Field capture on accept; CRC field spliced in at bits N..N+14 in ST_CAPT.
  always_ff @(posedge clk) begin
    if (accept) begin
      n_q   <= n_d;
      buf_q <= {1'b0, id, rtr, 2'b00, dlc, data, 15'd0};
    end else if (state_q == ST_CAPT) begin
      buf_q <= (buf_q & ~({83'd0, 15'h7FFF} << crc_sh)) | ({83'd0, crc_frm} << crc_sh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_en_q  <= 1'b0;
      crc_bit_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_BUILD;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            crc_en_q  <= 1'b1;
            crc_bit_q <= 1'b0;     // SOF
            idx_q     <= 7'd1;
          end
        end
        ST_BUILD: begin
          if (idx_q == n_q) begin
            state_q   <= ST_CAPT;
            crc_en_q  <= 1'b0;
            crc_bit_q <= 1'b0;
            idx_q     <= '0;
          end else begin
            crc_bit_q <= frame_bit;
            idx_q     <= idx_q + 7'd1;
          end
        end
        ST_CAPT: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bit_tick) begin
            state_q <= ST_TX_STUFF;
            idx_q   <= idx_q + 7'd1;
          end
        end
        ST_TX_STUFF: begin
          if (bit_tick) begin
            if (region_en) begin
              if (consume) idx_q <= idx_q + 7'd1;
            end else begin
              // This tick already carries the CRC delimiter.
              state_q <= ST_TX_TAIL;
              cnt_q   <= 4'd1;
            end
          end
        end
        ST_TX_TAIL: begin
          if (bit_tick) begin
            if (cnt_q == 4'(CAN_TAIL_BITS - 1)) begin
              state_q <= ST_IFS;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_IFS: begin
          if (bit_tick) begin
            if (cnt_q == 4'(IFS_BITS - 1)) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
